// File: rtl/axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axi_bridge_pkg
// Description : Shared types, AXI constants and byte-strobe helper for the
//               cache-to-AXI3 bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_bridge_pkg;

  // Bridge FSM states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  // SRAM-like transfer size codes
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Byte-lane strobe for a single beat; size 3 is illegal and enables no lane
  function automatic logic [3:0] strb_gen(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << addr_lo;
      SIZE_HALF: strb = 4'b0011 << {addr_lo[1], 1'b0};
      SIZE_WORD: strb = 4'b1111;
      default:   strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_axi_bridge_if.sv
`default_nettype none
// ============================================================================
// Interface   : cache_axi_bridge_if
// Description : Cache-side SRAM-like ports (inst/data) plus the AXI3 master
//               channels of the bridge, with bridge/environment modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_axi_bridge_if;

  // Instruction-side SRAM-like port
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;

  // Data-side SRAM-like port
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;

  // AXI3 read address / read data
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  // AXI3 write address / write data / write response
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  // Bridge side: consumes cache requests, drives the AXI master channels
  modport master (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_rdata, inst_addr_ok, inst_data_ok,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  // Environment side: the cache and the AXI memory subsystem
  modport slave (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_rdata, inst_addr_ok, inst_data_ok,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface
`default_nettype wire

// File: rtl/cache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cache_axi_bridge
// Description : Arbitrates the cache inst/data SRAM-like ports onto a single
//               AXI3 master, one single-beat transaction outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_axi_bridge #(
  parameter logic [3:0] INST_ID    = 4'd0,
  parameter logic [3:0] DATA_ID    = 4'd1,
  parameter bit         DATA_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  cache_axi_bridge_if.master bus
);
  import axi_bridge_pkg::*;

  state_e      state_q;
  logic        owner_q;                 // 1: data port owns the transaction
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic        aw_done_q, w_done_q;
  logic [31:0] inst_rdata_q, data_rdata_q;

  logic        w_idle, w_gnt_data, w_gnt_inst;
  logic        w_req_wr;
  logic [1:0]  w_req_size;
  logic [31:0] w_req_addr, w_req_wdata;
  logic        w_r_fire, w_b_fire, w_aw_fire, w_w_fire;
  logic        aw_done_d, w_done_d;
  logic [3:0]  w_axi_id;

  // Grant is only offered in IDLE and never while reset is held
  assign w_idle     = (state_q == ST_IDLE) && !rst;
  assign w_gnt_data = w_idle && bus.data_req && (DATA_FIRST || !bus.inst_req);
  assign w_gnt_inst = w_idle && bus.inst_req && !w_gnt_data;

  assign w_req_wr    = w_gnt_data ? bus.data_wr    : bus.inst_wr;
  assign w_req_size  = w_gnt_data ? bus.data_size  : bus.inst_size;
  assign w_req_addr  = w_gnt_data ? bus.data_addr  : bus.inst_addr;
  assign w_req_wdata = w_gnt_data ? bus.data_wdata : bus.inst_wdata;

  assign w_r_fire  = (state_q == ST_R) && rready_q && bus.rvalid;
  assign w_b_fire  = (state_q == ST_B) && bready_q && bus.bvalid;
  assign w_aw_fire = awvalid_q && bus.awready;
  assign w_w_fire  = wvalid_q && bus.wready;
  assign aw_done_d = aw_done_q || w_aw_fire;
  assign w_done_d  = w_done_q || w_w_fire;

  // Transaction FSM with capture registers and registered AXI handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_gnt_data || w_gnt_inst) begin
            owner_q <= w_gnt_data;
            wr_q    <= w_req_wr;
            size_q  <= w_req_size;
            addr_q  <= w_req_addr;
            wdata_q <= w_req_wdata;
            if (w_req_wr) begin
              state_q   <= ST_AW_W;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= ST_AR;
              arvalid_q <= 1'b1;
            end
          end
        end
        ST_AR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_R;
          end
        end
        ST_R: begin
          if (bus.rvalid) begin
            rready_q <= 1'b0;
            state_q  <= ST_IDLE;
            if (owner_q) data_rdata_q <= bus.rdata;
            else         inst_rdata_q <= bus.rdata;
          end
        end
        ST_AW_W: begin
          // AW and W complete independently; move on once both have
          if (aw_done_d && w_done_d) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b1;
            state_q   <= ST_B;
          end else begin
            if (w_aw_fire) awvalid_q <= 1'b0;
            if (w_w_fire)  wvalid_q  <= 1'b0;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
          end
        end
        ST_B: begin
          if (bus.bvalid) begin
            bready_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign w_axi_id = owner_q ? DATA_ID : INST_ID;

  // Cache-side responses
  assign bus.inst_addr_ok = w_gnt_inst;
  assign bus.data_addr_ok = w_gnt_data;
  assign bus.inst_data_ok = (w_r_fire || w_b_fire) && !owner_q;
  assign bus.data_data_ok = (w_r_fire || w_b_fire) && owner_q;
  assign bus.inst_rdata   = (w_r_fire && !owner_q) ? bus.rdata : inst_rdata_q;
  assign bus.data_rdata   = (w_r_fire && owner_q)  ? bus.rdata : data_rdata_q;

  // Read channels
  assign bus.arid    = w_axi_id;
  assign bus.araddr  = addr_q;
  assign bus.arlen   = AXI_LEN_SINGLE;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arburst = AXI_BURST_INCR;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'b0000;
  assign bus.arprot  = 3'b000;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;

  // Write channels
  assign bus.awid    = w_axi_id;
  assign bus.awaddr  = addr_q;
  assign bus.awlen   = AXI_LEN_SINGLE;
  assign bus.awsize  = {1'b0, size_q};
  assign bus.awburst = AXI_BURST_INCR;
  assign bus.awlock  = 2'b00;
  assign bus.awcache = 4'b0000;
  assign bus.awprot  = 3'b000;
  assign bus.awvalid = awvalid_q;
  assign bus.wid     = w_axi_id;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = strb_gen(size_q, addr_q[1:0]);
  assign bus.wlast   = 1'b1;
  assign bus.wvalid  = wvalid_q;
  assign bus.bready  = bready_q;

  // Response IDs/status are not needed with a single outstanding transaction
  logic unused_ok;
  assign unused_ok = ^{bus.rid, bus.rresp, bus.rlast, bus.bid, bus.bresp, wr_q};

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_axi_bridge
// Description : Self-checking bench for cache_axi_bridge: directed scenarios
//               followed by random single-beat traffic against a memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_axi_bridge;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [logic [29:0]];
  logic [31:0] last_rd [2];          // expected held rdata, [0]=inst [1]=data

  cache_axi_bridge_if bus ();

  cache_axi_bridge #(
    .INST_ID    (4'd0),
    .DATA_ID    (4'd1),
    .DATA_FIRST (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model: unknown words get random content on first read
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a[31:2])) mem[a[31:2]] = $urandom;
    return mem[a[31:2]];
  endfunction

  // Lanes covered by an naturally aligned 1/2/4-byte access containing addr
  function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] s;
    int n, base;
    s = 4'b0000;
    if (sz != 2'd3) begin
      n    = 1 << sz;
      base = (int'(lo) / n) * n;
      for (int i = 0; i < 4; i++)
        if (i >= base && i < base + n) s[i] = 1'b1;
    end
    return s;
  endfunction

  function automatic void mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    logic [31:0] w;
    logic [3:0]  s;
    w = mem_rd(a);
    s = exp_strb(sz, a[1:0]);
    for (int i = 0; i < 4; i++)
      if (s[i]) w[i*8 +: 8] = d[i*8 +: 8];
    mem[a[31:2]] = w;
  endfunction

  task automatic cyc_begin();
    @(posedge clk);
    #1;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = $urandom;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
  endtask

  task automatic drop_req(input bit port);
    if (port) bus.data_req = 1'b0;
    else      bus.inst_req = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valids"}, {29'd0, bus.arvalid, bus.awvalid, bus.wvalid}, 32'd0);
    chk({tag, "_readys"}, {30'd0, bus.rready, bus.bready}, 32'd0);
    chk({tag, "_data_ok"}, {30'd0, bus.inst_data_ok, bus.data_data_ok}, 32'd0);
  endtask

  // One request cycle in IDLE: the named port must be granted immediately
  task automatic issue(input bit port, input bit wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    cyc_begin();
    if (port) begin
      bus.data_req = 1'b1; bus.data_wr = wr; bus.data_size = sz;
      bus.data_addr = a;   bus.data_wdata = wd;
    end else begin
      bus.inst_req = 1'b1; bus.inst_wr = wr; bus.inst_size = sz;
      bus.inst_addr = a;   bus.inst_wdata = wd;
    end
    #1;
    chk("addr_ok_owner", port ? bus.data_addr_ok : bus.inst_addr_ok, 32'd1);
    chk("addr_ok_other", port ? bus.inst_addr_ok : bus.data_addr_ok, 32'd0);
    check_idle_outputs("idle");
  endtask

  task automatic serve_ar(input bit port, input logic [31:0] a, input logic [1:0] sz, input int d1);
    for (int t = 0; ; t++) begin
      cyc_begin();
      if (t == 0) drop_req(port);
      bus.arready = (t >= d1);
      #1;
      chk("arvalid_hold", bus.arvalid, 32'd1);
      chk("addr_ok_busy", {bus.inst_addr_ok, bus.data_addr_ok}, 32'd0);
      chk("data_ok_ar", {bus.inst_data_ok, bus.data_data_ok}, 32'd0);
      if (bus.arready) begin
        chk("araddr", bus.araddr, a);
        chk("arid", bus.arid, port ? 32'd1 : 32'd0);
        chk("arsize", bus.arsize, {30'd0, sz});
        chk("arlen_burst", {bus.arlen, bus.arburst}, {22'd0, 8'd0, 2'b01});
        break;
      end
      if (t > 30) begin chk("ar_timeout", 32'd1, 32'd0); break; end
    end
  endtask

  task automatic serve_r(input bit port, input logic [31:0] a, input int d2);
    logic [31:0] exp;
    exp = mem_rd(a);
    for (int t = 0; ; t++) begin
      cyc_begin();
      bus.rvalid = (t >= d2);
      if (bus.rvalid) bus.rdata = exp;
      #1;
      chk("rready", bus.rready, 32'd1);
      chk("arvalid_in_r", bus.arvalid, 32'd0);
      chk("addr_ok_r", {bus.inst_addr_ok, bus.data_addr_ok}, 32'd0);
      if (bus.rvalid) begin
        chk("data_ok_owner_r", port ? bus.data_data_ok : bus.inst_data_ok, 32'd1);
        chk("data_ok_other_r", port ? bus.inst_data_ok : bus.data_data_ok, 32'd0);
        chk("rdata_owner", port ? bus.data_rdata : bus.inst_rdata, exp);
        chk("rdata_other", port ? bus.inst_rdata : bus.data_rdata, last_rd[!port]);
        last_rd[port] = exp;
        break;
      end
      chk("data_ok_wait_r", {bus.inst_data_ok, bus.data_data_ok}, 32'd0);
      chk("rdata_hold", port ? bus.data_rdata : bus.inst_rdata, last_rd[port]);
      if (t > 30) begin chk("r_timeout", 32'd1, 32'd0); break; end
    end
  endtask

  task automatic serve_write(input bit port, input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] wd, input int d1, input int d2, input int d3);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    for (int t = 0; ; t++) begin
      cyc_begin();
      if (t == 0) drop_req(port);
      bus.awready = !aw_done && (t >= d1);
      bus.wready  = !w_done && (t >= d2);
      #1;
      chk("awvalid", bus.awvalid, {31'd0, !aw_done});
      chk("wvalid", bus.wvalid, {31'd0, !w_done});
      chk("addr_ok_w", {bus.inst_addr_ok, bus.data_addr_ok}, 32'd0);
      if (bus.awready) begin
        chk("awaddr", bus.awaddr, a);
        chk("awid", bus.awid, port ? 32'd1 : 32'd0);
        chk("awsize", bus.awsize, {30'd0, sz});
      end
      if (bus.wready) begin
        chk("wdata", bus.wdata, wd);
        chk("wstrb", bus.wstrb, {28'd0, exp_strb(sz, a[1:0])});
        chk("wid_wlast", {bus.wid, bus.wlast}, {27'd0, (port ? 4'd1 : 4'd0), 1'b1});
      end
      aw_done = aw_done || bus.awready;
      w_done  = w_done || bus.wready;
      if (aw_done && w_done) break;
      if (t > 30) begin chk("aw_w_timeout", 32'd1, 32'd0); break; end
    end
    mem_wr(a, wd, sz);
    for (int t = 0; ; t++) begin
      cyc_begin();
      bus.bvalid = (t >= d3);
      #1;
      chk("b_valids_low", {bus.awvalid, bus.wvalid}, 32'd0);
      chk("bready", bus.bready, 32'd1);
      if (bus.bvalid) begin
        chk("data_ok_owner_b", port ? bus.data_data_ok : bus.inst_data_ok, 32'd1);
        chk("data_ok_other_b", port ? bus.inst_data_ok : bus.data_data_ok, 32'd0);
        break;
      end
      chk("data_ok_wait_b", {bus.inst_data_ok, bus.data_data_ok}, 32'd0);
      if (t > 30) begin chk("b_timeout", 32'd1, 32'd0); break; end
    end
  endtask

  initial begin
    bit          port, wr;
    logic [1:0]  sz;
    logic [31:0] a, wd;

    rst = 1'b1;
    bus.inst_req = 1'b0; bus.inst_wr = 1'b0; bus.inst_size = 2'd0;
    bus.inst_addr = 32'd0; bus.inst_wdata = 32'd0;
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_size = 2'd0;
    bus.data_addr = 32'd0; bus.data_wdata = 32'd0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'd0; bus.rid = 4'd0;
    bus.rresp = 2'd0; bus.rlast = 1'b1; bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid = 1'b0; bus.bid = 4'd0; bus.bresp = 2'd0;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_addr_ok", {bus.inst_addr_ok, bus.data_addr_ok}, 32'd0);
    chk("reset_rdata", bus.inst_rdata | bus.data_rdata, 32'd0);
    rst = 1'b0;

    // Data word read, arready after 2 cycles, rvalid after 3
    mem[30'(32'h1FC0_0010 >> 2)] = 32'hDEAD_BEEF;
    issue(1'b1, 1'b0, 2'd2, 32'h1FC0_0010, 32'd0);
    serve_ar(1'b1, 32'h1FC0_0010, 2'd2, 2);
    serve_r(1'b1, 32'h1FC0_0010, 3);

    // Simultaneous requests: data wins, inst granted the cycle after data_ok
    cyc_begin();
    bus.inst_req = 1'b1; bus.inst_wr = 1'b0; bus.inst_size = 2'd2; bus.inst_addr = 32'h0000_1000;
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_size = 2'd2; bus.data_addr = 32'h0000_2004;
    #1;
    chk("both_data_addr_ok", bus.data_addr_ok, 32'd1);
    chk("both_inst_addr_ok", bus.inst_addr_ok, 32'd0);
    serve_ar(1'b1, 32'h0000_2004, 2'd2, 1);
    serve_r(1'b1, 32'h0000_2004, 1);
    issue(1'b0, 1'b0, 2'd2, 32'h0000_1000, 32'd0);
    serve_ar(1'b0, 32'h0000_1000, 2'd2, 0);
    serve_r(1'b0, 32'h0000_1000, 0);

    // Byte write at offset 3, awready two cycles ahead of wready
    issue(1'b1, 1'b1, 2'd0, 32'h0000_3003, 32'hAB00_0000);
    serve_write(1'b1, 32'h0000_3003, 2'd0, 32'hAB00_0000, 0, 2, 1);

    // Half write at offset 2, AW and W accepted together
    issue(1'b1, 1'b1, 2'd1, 32'h0000_3002, 32'h1234_0000);
    serve_write(1'b1, 32'h0000_3002, 2'd1, 32'h1234_0000, 0, 0, 0);

    // Asynchronous reset in the middle of R
    issue(1'b1, 1'b0, 2'd2, 32'h0000_4000, 32'd0);
    serve_ar(1'b1, 32'h0000_4000, 2'd2, 0);
    cyc_begin();
    #1;
    chk("pre_rst_rready", bus.rready, 32'd1);
    bus.inst_req = 1'b1;
    rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    chk("async_rst_addr_ok", bus.inst_addr_ok, 32'd0);
    chk("async_rst_rdata", bus.inst_rdata | bus.data_rdata, 32'd0);
    bus.inst_req = 1'b0;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(1'b1, 1'b0, 2'd2, 32'h0000_4000, 32'd0);
    serve_ar(1'b1, 32'h0000_4000, 2'd2, 1);
    serve_r(1'b1, 32'h0000_4000, 2);

    // Random single-port traffic against the memory model
    for (int n = 0; n < 40; n++) begin
      port = 1'($urandom_range(0, 1));
      wr   = port ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 5) == 0);
      sz   = wr ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
      a    = 32'h1000_0000 | 32'($urandom_range(0, 63));
      wd   = $urandom;
      issue(port, wr, sz, a, wd);
      if (wr) begin
        serve_write(port, a, sz, wd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        serve_ar(port, a, sz, $urandom_range(0, 3));
        serve_r(port, a, $urandom_range(0, 3));
      end
    end

    cyc_begin();
    #1;
    check_idle_outputs("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
Converts the cache block's two SRAM-like miss/uncached ports (instruction and data) into one AXI3 master port to the memory subsystem. It sits directly downstream of the cache top and connects to its cache_inst_* and cache_data_* outputs. It arbitrates with data priority and keeps exactly one transaction outstanding. Every transfer is a single beat (len=0).

Parameters:
INST_ID, 4'd0, ARID driven for instruction reads
DATA_ID, 4'd1, ARID/AWID/WID driven for data transactions
DATA_FIRST, 1, 1: data port wins simultaneous requests; 0: instruction port wins

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
inst_req/inst_wr  in  1/1  instruction-side request, write flag
inst_size  in  2  0 byte, 1 half, 2 word
inst_addr/inst_wdata  in  32/32  byte address, write data (already lane-aligned)
inst_rdata  out  32  read data
inst_addr_ok/inst_data_ok  out  1/1  request accepted / transaction complete
data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok: same widths and meaning, data side
arid/araddr/arsize/arvalid  out  4/32/3/1  read address channel
arlen/arburst/arlock/arcache/arprot  out  8/2/2/4/3  constants 0/2'b01/0/0/0
arready  in  1
rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1 ; rready out 1
awid/awaddr/awsize/awvalid  out  4/32/3/1 ; awlen/awburst/awlock/awcache/awprot same constants as AR ; awready in 1
wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1 ; wready in 1
bid/bresp/bvalid  in  4/2/1 ; bready out 1

Behaviour:
- Reset (async, any state): FSM to IDLE. arvalid, rready, awvalid, wvalid, bready, both addr_ok and both data_ok = 0. Captured registers cleared to 0.
- FSM states: IDLE, AR, R, AW_W, B.
- IDLE:
  - addr_ok is combinational and goes high only to the granted port: grant = the port with req; if both request, the port chosen by DATA_FIRST.
  - On the grant cycle, capture owner, wr, size, addr, wdata. Next state is AR when wr=0, AW_W when wr=1.
  - addr_ok = 0 in every non-IDLE state.
- AR:
  - arvalid=1; araddr, arsize and arid come from registers; arsize={1'b0,size}.
  - Stay until arready, then go to R.
- R:
  - rready=1. When rvalid: owner's data_ok=1 for that cycle, owner's rdata=rdata (combinational pass-through), then go to IDLE.
  - rresp and rid are ignored. The non-owner's rdata holds its last value.
- AW_W:
  - awvalid and wvalid assert together. Each deasserts independently after its own handshake, tracked by aw_done and w_done flags.
  - Handshakes may occur in the same cycle or in either order. Enter B when both are done; flags clear on leaving.
  - wlast=1. wdata comes from register.
  - wstrb: size 0 gives 4'b0001<<addr[1:0]; size 1 gives 4'b0011<<{addr[1],1'b0}; size 2 gives 4'b1111; size 3 is illegal and drives 4'b0000.
- B: bready=1. On bvalid, owner's data_ok pulses for 1 cycle, then go to IDLE. bresp is ignored.
- Latency: addr_ok arrives the same cycle as req in IDLE. arvalid/awvalid arrive on the next cycle. data_ok arrives in the same cycle as the rvalid&rready or bvalid&bready handshake.
- Back-to-back: the earliest new addr_ok is the cycle after data_ok, because IDLE is re-entered then.
- A request on either port while busy stalls silently (addr_ok=0); the cache holds req.
- The instruction port is normally read-only. An inst write is still legal and travels the write path with awid=INST_ID.
- No AXI valid drops before its ready.

Decomposition:
- Shared package axi_bridge_pkg holds:
  - the state enum
  - localparams AXI_BURST_INCR=2'b01 and AXI_LEN_SINGLE=8'd0
  - size codes
  - a function strb_gen(size, addr_lo)
- No sub-module is needed: one FSM plus a capture register set, about 200 lines.

Test Plan:
- Data read word at 0x1FC0_0010, arready after 2 cycles, rvalid after 3 with rdata=0xDEADBEEF -> exactly one cycle data_addr_ok; arid=1, arsize=2; data_data_ok=1 with data_rdata=0xDEADBEEF in the handshake cycle; no inst_* pulses.
- inst_req and data_req both asserted in the same cycle (DATA_FIRST=1) -> data_addr_ok first. inst_addr_ok follows on the cycle after data_data_ok, with araddr equal to inst_addr and arid=0.
- Byte write to addr 0x...03, awready before wready (2-cycle gap) -> awvalid drops after its handshake while wvalid stays high; wstrb=4'b1000; data_data_ok exactly one cycle, on bvalid.
- Half write to addr 0x...02 with awready and wready in the same cycle -> wstrb=4'b1100. B entered next cycle; awvalid and wvalid both low in B.
- rst asserted mid-R with rvalid still pending -> outputs zero the same cycle (async), FSM in IDLE. A fresh read after rst drops completes normally.
